// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM states
// and default latencies.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational arithmetic core of the MDU: produces {hi,lo} for mult/multu/div/divu
// and flags a zero divisor so the caller can leave HI/LO untouched.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [2:0]  i_op,
  output logic [63:0] o_result,
  output logic        o_div0
);

  logic signed [31:0] w_sa;
  logic signed [31:0] w_sb;
  logic signed [63:0] w_sa64;
  logic signed [63:0] w_sb64;
  logic               w_div_ovf;

  assign w_sa      = i_a;
  assign w_sb      = i_b;
  assign w_sa64    = {{32{i_a[31]}}, i_a};
  assign w_sb64    = {{32{i_b[31]}}, i_b};
  // Most-negative / -1 cannot be represented; pin the result rather than trust the operator.
  assign w_div_ovf = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

  always_comb begin
    o_result = '0;
    o_div0   = 1'b0;
    case (i_op)
      MD_MULT:  o_result = w_sa64 * w_sb64;
      MD_MULTU: o_result = {32'd0, i_a} * {32'd0, i_b};
      MD_DIV: begin
        if (i_b == 32'd0) begin
          o_div0 = 1'b1;
        end else if (w_div_ovf) begin
          o_result = {32'd0, 32'h8000_0000};
        end else begin
          o_result = {w_sa % w_sb, w_sa / w_sb};
        end
      end
      MD_DIVU: begin
        if (i_b == 32'd0) begin
          o_div0 = 1'b1;
        end else begin
          o_result = {i_a % i_b, i_a / i_b};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// E-stage multiply/divide unit: owns HI/LO, computes at the start edge and commits
// after a fixed busy latency so the hazard unit can stall on busy.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MD_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CNT_W = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);

  mdu_state_e       r_state;
  mdu_state_e       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_hi_tmp;
  logic [31:0]      r_lo_tmp;
  logic             r_div0;
  logic             w_capture;
  logic             w_commit;
  logic             w_write_hi;
  logic             w_write_lo;
  logic [63:0]      w_calc_result;
  logic             w_calc_div0;

  mdu_calc u_calc (
    .i_a      (A),
    .i_b      (B),
    .i_op     (MD_op),
    .o_result (w_calc_result),
    .o_div0   (w_calc_div0)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_capture    = 1'b0;
    w_commit     = 1'b0;
    w_write_hi   = 1'b0;
    w_write_lo   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          case (MD_op)
            MD_MULT, MD_MULTU: begin
              w_capture    = 1'b1;
              w_next_cnt   = CNT_W'(MULT_CYCLES);
              w_next_state = S_RUN;
            end
            MD_DIV, MD_DIVU: begin
              w_capture    = 1'b1;
              w_next_cnt   = CNT_W'(DIV_CYCLES);
              w_next_state = S_RUN;
            end
            MD_MTHI: w_write_hi = 1'b1;
            MD_MTLO: w_write_lo = 1'b1;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        // A start seen here is deliberately ignored; only the countdown advances.
        w_next_cnt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_commit     = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_hi_tmp <= '0;
      r_lo_tmp <= '0;
      r_div0   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_capture) begin
        r_hi_tmp <= w_calc_result[63:32];
        r_lo_tmp <= w_calc_result[31:0];
        r_div0   <= w_calc_div0;
      end
      if (w_commit && !r_div0) begin
        r_hi <= r_hi_tmp;
        r_lo <= r_lo_tmp;
      end
      if (w_write_hi) r_hi <= A;
      if (w_write_lo) r_lo <= A;
    end
  end

  assign busy = (r_state == S_RUN);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule
